noite_lobinho: RTL and testbench

NOITE_LOBINHO -- requirements
Module: noite_lobinho

---
 rtl/noite_lobinho.sv | 199 +++++++++++++++++++
 tb/tb_noite_lobinho.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noite_lobinho.sv
// Night-phase sequencer for a werewolf party game: walks the living players in
// order, latches wolf/doctor/seer choices, resolves the kill and checks for a winner.
module noite_lobinho #(
  parameter int N_JOG = 5,
  localparam int WJ = $clog2(N_JOG)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               novo_jogo,
  input  logic               iniciar,
  input  logic               passa,
  input  logic [N_JOG-1:0]   botoes,
  input  logic [2*N_JOG-1:0] classes,
  output logic [WJ-1:0]      jogador_atual,
  output logic [N_JOG-1:0]   vivos,
  output logic [WJ-1:0]      atacado,
  output logic [WJ-1:0]      protegido,
  output logic               atacado_valido,
  output logic               protegido_valido,
  output logic               revela_valido,
  output logic               revela_lobo,
  output logic               morte,
  output logic [WJ-1:0]      morto,
  output logic               fim_noite,
  output logic               lobos_venceram,
  output logic               aldeoes_venceram,
  output logic [3:0]         db_estado
);

  localparam logic [2:0] OCIOSO   = 3'd0;
  localparam logic [2:0] BUSCA    = 3'd1;
  localparam logic [2:0] VEZ      = 3'd2;
  localparam logic [2:0] PROXIMO  = 3'd3;
  localparam logic [2:0] RESOLVE  = 3'd4;
  localparam logic [2:0] VERIFICA = 3'd5;
  localparam logic [2:0] FIM_JOGO = 3'd6;

  localparam logic [1:0] ALDEAO  = 2'd0;
  localparam logic [1:0] LOBO    = 2'd1;
  localparam logic [1:0] MEDICO  = 2'd2;
  localparam logic [1:0] VIDENTE = 2'd3;

  localparam logic [WJ-1:0] ULTIMO = WJ'(N_JOG - 1);

  logic [2:0]    estado;
  logic [WJ-1:0] escolha;
  logic          escolha_valida;
  logic [WJ-1:0] sel_idx;
  logic          sel_ok;
  logic [1:0]    papel_atual;
  logic [1:0]    papel_escolha;
  logic          passa_ok;
  logic          mata;
  logic [WJ:0]   n_lobos;
  logic [WJ:0]   n_aldeoes;

  assign db_estado = {1'b0, estado};

  // A selection counts only if it is a single living player other than the chooser.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_JOG; i++) begin
      if (botoes[i]) sel_idx = WJ'(i);
    end
    sel_ok = $onehot(botoes) && ((botoes & vivos) != '0) && !botoes[jogador_atual];
  end

  assign papel_atual   = classes[{jogador_atual, 1'b0} +: 2];
  assign papel_escolha = classes[{escolha, 1'b0} +: 2];
  assign passa_ok      = passa && ((papel_atual == ALDEAO) || escolha_valida);
  assign mata          = atacado_valido && !(protegido_valido && (protegido == atacado));

  always_comb begin
    n_lobos   = '0;
    n_aldeoes = '0;
    for (int i = 0; i < N_JOG; i++) begin
      if (vivos[i]) begin
        if (classes[2*i +: 2] == LOBO) n_lobos = n_lobos + (WJ+1)'(1);
        else                           n_aldeoes = n_aldeoes + (WJ+1)'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado           <= OCIOSO;
      vivos            <= {N_JOG{1'b1}};
      jogador_atual    <= '0;
      atacado          <= '0;
      protegido        <= '0;
      atacado_valido   <= 1'b0;
      protegido_valido <= 1'b0;
      revela_valido    <= 1'b0;
      revela_lobo      <= 1'b0;
      morte            <= 1'b0;
      morto            <= '0;
      fim_noite        <= 1'b0;
      lobos_venceram   <= 1'b0;
      aldeoes_venceram <= 1'b0;
      escolha          <= '0;
      escolha_valida   <= 1'b0;
    end else if (novo_jogo) begin
      estado           <= OCIOSO;
      vivos            <= {N_JOG{1'b1}};
      jogador_atual    <= '0;
      atacado_valido   <= 1'b0;
      protegido_valido <= 1'b0;
      revela_valido    <= 1'b0;
      morte            <= 1'b0;
      fim_noite        <= 1'b0;
      lobos_venceram   <= 1'b0;
      aldeoes_venceram <= 1'b0;
      escolha          <= '0;
      escolha_valida   <= 1'b0;
    end else begin
      morte     <= 1'b0;
      fim_noite <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            estado           <= BUSCA;
            jogador_atual    <= '0;
            atacado_valido   <= 1'b0;
            protegido_valido <= 1'b0;
            revela_valido    <= 1'b0;
            escolha          <= '0;
            escolha_valida   <= 1'b0;
          end
        end
        BUSCA: begin
          if (vivos[jogador_atual]) begin
            estado <= VEZ;
          end else if (jogador_atual < ULTIMO) begin
            jogador_atual <= jogador_atual + WJ'(1);
          end else begin
            // morte is registered on entry so it is high for exactly the RESOLVE cycle
            estado        <= RESOLVE;
            morte         <= mata;
            revela_valido <= 1'b0;
            if (mata) morto <= atacado;
          end
        end
        VEZ: begin
          if (passa_ok) begin
            case (papel_atual)
              LOBO: begin
                atacado        <= escolha;
                atacado_valido <= 1'b1;
              end
              MEDICO: begin
                protegido        <= escolha;
                protegido_valido <= 1'b1;
              end
              default: ;
            endcase
            revela_valido <= (papel_atual == VIDENTE);
            if (papel_atual == VIDENTE) revela_lobo <= (papel_escolha == LOBO);
            escolha        <= '0;
            escolha_valida <= 1'b0;
            estado         <= PROXIMO;
          end else if (sel_ok) begin
            escolha        <= sel_idx;
            escolha_valida <= 1'b1;
          end
        end
        PROXIMO: begin
          if (jogador_atual < ULTIMO) begin
            jogador_atual <= jogador_atual + WJ'(1);
            estado        <= BUSCA;
          end else begin
            estado        <= RESOLVE;
            morte         <= mata;
            revela_valido <= 1'b0;
            if (mata) morto <= atacado;
          end
        end
        RESOLVE: begin
          if (morte) vivos[atacado] <= 1'b0;
          fim_noite <= 1'b1;
          estado    <= VERIFICA;
        end
        VERIFICA: begin
          if (n_lobos == '0) begin
            aldeoes_venceram <= 1'b1;
            estado           <= FIM_JOGO;
          end else if (n_lobos >= n_aldeoes) begin
            lobos_venceram <= 1'b1;
            estado         <= FIM_JOGO;
          end else begin
            estado <= OCIOSO;
          end
        end
        FIM_JOGO: ;
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_noite_lobinho.sv
// Randomized games of noite_lobinho checked against a player-level model of the rules.
module tb_noite_lobinho;
  localparam int N = 5;
  localparam int WJ = $clog2(N);
  localparam int ALDEAO = 0, LOBO = 1, MEDICO = 2, VIDENTE = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           novo_jogo = 1'b0;
  logic           iniciar = 1'b0;
  logic           passa = 1'b0;
  logic [N-1:0]   botoes = '0;
  logic [2*N-1:0] classes = '0;
  logic [WJ-1:0]  jogador_atual, atacado, protegido, morto;
  logic [N-1:0]   vivos;
  logic           atacado_valido, protegido_valido, revela_valido, revela_lobo;
  logic           morte, fim_noite, lobos_venceram, aldeoes_venceram;
  logic [3:0]     db_estado;

  noite_lobinho #(.N_JOG(N)) dut (
    .clock(clock), .reset(reset), .novo_jogo(novo_jogo), .iniciar(iniciar),
    .passa(passa), .botoes(botoes), .classes(classes),
    .jogador_atual(jogador_atual), .vivos(vivos), .atacado(atacado),
    .protegido(protegido), .atacado_valido(atacado_valido),
    .protegido_valido(protegido_valido), .revela_valido(revela_valido),
    .revela_lobo(revela_lobo), .morte(morte), .morto(morto),
    .fim_noite(fim_noite), .lobos_venceram(lobos_venceram),
    .aldeoes_venceram(aldeoes_venceram), .db_estado(db_estado)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard and model state
  int n_checks = 0;
  int n_err = 0;
  logic [WJ-1:0] exp_q[$];
  int papel[N];
  bit m_vivos[N];
  bit atk_v, prot_v;
  int atk, prot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N-1:0] vivos_modelo();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_vivos[i];
    return v;
  endfunction

  task automatic aplica_classes();
    for (int i = 0; i < N; i++) classes[2*i +: 2] = 2'(papel[i]);
  endtask

  function automatic int alvo_aleatorio(input int p);
    int cand[$];
    for (int i = 0; i < N; i++) if (m_vivos[i] && i != p) cand.push_back(i);
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  task automatic espera(input logic [3:0] st, input int exp_n, input string tag);
    int n;
    n = 0;
    while (db_estado != st && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_estado"}, 32'(db_estado), 32'(st));
    check({tag, "_ciclos"}, n, exp_n);
  endtask

  task automatic tenta_invalido(input logic [N-1:0] b, input int p, input string tag);
    botoes = b;
    tick();
    botoes = '0;
    passa = 1'b1;
    tick();
    passa = 1'b0;
    check({tag, "_estado"}, 32'(db_estado), 2);
    check({tag, "_jogador"}, 32'(jogador_atual), p);
  endtask

  // one player's turn: optional illegal attempts, then a legal choice and passa
  task automatic turno(input int p);
    int r, t, a, b, dd;
    logic [N-1:0] bb;
    r = papel[p];
    t = 0;
    check("vez_jogador", 32'(jogador_atual), p);
    if (r != ALDEAO) begin
      if ($urandom_range(0, 1) == 1) begin
        passa = 1'b1;
        tick();
        passa = 1'b0;
        check("passa_sem_escolha", 32'(db_estado), 2);
      end
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, N - 1);
        b = (a + $urandom_range(1, N - 1)) % N;
        bb = '0; bb[a] = 1'b1; bb[b] = 1'b1;
        tenta_invalido(bb, p, "dois_botoes");
      end
      if ($urandom_range(0, 1) == 1) begin
        bb = '0; bb[p] = 1'b1;
        tenta_invalido(bb, p, "auto_escolha");
      end
      dd = -1;
      for (int i = 0; i < N; i++) if (!m_vivos[i] && i != p) dd = i;
      if (dd >= 0 && $urandom_range(0, 1) == 1) begin
        bb = '0; bb[dd] = 1'b1;
        tenta_invalido(bb, p, "alvo_morto");
      end
    end
    if (r != ALDEAO || $urandom_range(0, 1) == 1) begin
      if ($urandom_range(0, 2) == 0) begin
        botoes = '0;
        botoes[alvo_aleatorio(p)] = 1'b1;
        tick();
        botoes = '0;
      end
      t = alvo_aleatorio(p);
      if (r == MEDICO && atk_v && atk != p && $urandom_range(0, 1) == 1) t = atk;
      botoes = '0;
      botoes[t] = 1'b1;
      tick();
      botoes = '0;
    end
    passa = 1'b1;
    tick();
    passa = 1'b0;
    check("avanca", 32'(db_estado), 3);
    if (r == LOBO) begin
      atk = t; atk_v = 1'b1;
      check("atacado", 32'(atacado), t);
      check("atacado_valido", 32'(atacado_valido), 1);
    end
    if (r == MEDICO) begin
      prot = t; prot_v = 1'b1;
      check("protegido", 32'(protegido), t);
      check("protegido_valido", 32'(protegido_valido), 1);
    end
    check("revela_valido", 32'(revela_valido), (r == VIDENTE) ? 1 : 0);
    if (r == VIDENTE) check("revela_lobo", 32'(revela_lobo), (papel[t] == LOBO) ? 1 : 0);
  endtask

  task automatic noite(output bit acabou);
    int prev, n_l, n_a;
    bit kill;
    check("vivos_inicio", 32'(vivos), 32'(vivos_modelo()));
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("busca_inicio", 32'(db_estado), 1);
    check("jogador_zero", 32'(jogador_atual), 0);
    check("atacado_limpo", 32'(atacado_valido), 0);
    check("protegido_limpo", 32'(protegido_valido), 0);
    atk_v = 1'b0;
    prot_v = 1'b0;
    prev = -1;
    for (int p = 0; p < N; p++) begin
      if (m_vivos[p]) begin
        espera(4'd2, (prev < 0) ? p + 1 : p - prev + 1, "vez");
        turno(p);
        prev = p;
      end
    end
    espera(4'd4, N - prev, "resolve");
    kill = atk_v && !(prot_v && prot == atk);
    check("morte", 32'(morte), kill ? 1 : 0);
    check("revela_fim_noite", 32'(revela_valido), 0);
    if (kill) begin
      exp_q.push_back(WJ'(atk));
      m_vivos[atk] = 1'b0;
    end
    if (morte) begin
      check("fila_morte", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) check("morto", 32'(morto), 32'(exp_q.pop_front()));
    end
    tick();
    check("verifica_estado", 32'(db_estado), 5);
    check("morte_um_ciclo", 32'(morte), 0);
    check("fim_noite", 32'(fim_noite), 1);
    check("vivos_pos_morte", 32'(vivos), 32'(vivos_modelo()));
    n_l = 0;
    n_a = 0;
    for (int i = 0; i < N; i++) begin
      if (m_vivos[i]) begin
        if (papel[i] == LOBO) n_l++;
        else n_a++;
      end
    end
    tick();
    check("fim_noite_pulso", 32'(fim_noite), 0);
    acabou = (n_l == 0) || (n_l >= n_a);
    check("estado_pos_noite", 32'(db_estado), acabou ? 6 : 0);
    check("aldeoes_venceram", 32'(aldeoes_venceram), (n_l == 0) ? 1 : 0);
    check("lobos_venceram", 32'(lobos_venceram), (n_l != 0 && n_l >= n_a) ? 1 : 0);
  endtask

  task automatic novo();
    novo_jogo = 1'b1;
    tick();
    novo_jogo = 1'b0;
    for (int i = 0; i < N; i++) m_vivos[i] = 1'b1;
    check("novo_estado", 32'(db_estado), 0);
    check("novo_vivos", 32'(vivos), 32'({N{1'b1}}));
    check("novo_flags", {30'd0, lobos_venceram, aldeoes_venceram}, 0);
    check("novo_alvos", {30'd0, atacado_valido, protegido_valido}, 0);
  endtask

  task automatic jogo(input bit fixo);
    bit acabou;
    int noites;
    for (int i = 0; i < N; i++) papel[i] = fixo ? ((i < 3) ? i + 1 : ALDEAO) : $urandom_range(0, 3);
    aplica_classes();
    novo();
    acabou = 1'b0;
    noites = 0;
    while (!acabou && noites < 8) begin
      noite(acabou);
      noites++;
    end
    if (acabou) begin
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      tick();
      check("fim_jogo_trava", 32'(db_estado), 6);
      check("fim_jogo_vivos", 32'(vivos), 32'(vivos_modelo()));
    end
  endtask

  initial begin
    bit acabou;
    for (int i = 0; i < N; i++) m_vivos[i] = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_estado", 32'(db_estado), 0);
    check("reset_vivos", 32'(vivos), 32'({N{1'b1}}));
    check("reset_saidas", {25'd0, atacado_valido, protegido_valido, revela_valido,
                           morte, fim_noite, lobos_venceram, aldeoes_venceram}, 0);
    reset = 1'b1;
    tick();

    jogo(1'b1);
    repeat (8) jogo(1'b0);

    // asynchronous reset while player 2 holds the turn
    for (int i = 0; i < N; i++) papel[i] = (i < 3) ? i + 1 : ALDEAO;
    aplica_classes();
    novo();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    atk_v = 1'b0;
    prot_v = 1'b0;
    espera(4'd2, 1, "rst_vez0");
    turno(0);
    espera(4'd2, 2, "rst_vez1");
    turno(1);
    espera(4'd2, 2, "rst_vez2");
    #3 reset = 1'b0;
    #1;
    check("rst_async_estado", 32'(db_estado), 0);
    check("rst_async_jogador", 32'(jogador_atual), 0);
    check("rst_async_alvos", {29'd0, atacado_valido, protegido_valido, revela_valido}, 0);
    check("rst_async_vivos", 32'(vivos), 32'({N{1'b1}}));
    @(negedge clock);
    reset = 1'b1;
    tick();
    noite(acabou);

    check("fila_vazia", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
